// File: rtl/cdb_result_buffer_pkg.sv
// Shared types and constants for the CDB result staging buffer.
package cdb_result_buffer_pkg;

    localparam int unsigned CDB_XLEN  = 32;
    localparam int unsigned CDB_RRN_W = 6;
    localparam int unsigned CDB_ARN_W = 5;

    // One finished result as broadcast on the common data bus.
    typedef struct packed {
        logic [CDB_XLEN-1:0]  data;
        logic [CDB_RRN_W-1:0] rrn;
        logic [CDB_ARN_W-1:0] arn;
        logic                 jmp;
        logic                 err;
    } cdb_entry_t;

endpackage : cdb_result_buffer_pkg

// File: rtl/cdb_result_buffer.sv
// Per-unit result staging FIFO in front of the CDB arbiter.
//
// - Holds finished results in order and requests the bus while it has any.
// - Drives the head entry onto the OR-merged CDB in cycles where the grant is high.
// - The result width is fixed by CDB_XLEN in the package.
// - Optional feature, enabled by defining CDB_BYPASS_EN: when the buffer is empty,
//   an incoming result may be sent straight to the bus in the same cycle.
module cdb_result_buffer
    import cdb_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_flush,
    input  logic                         i_valid,
    input  cdb_entry_t                   i_entry,
    output logic                         o_ready,
    output logic                         o_get_bus,
    input  logic                         i_bus_granted,
    output logic                         o_cdb_valid,
    output cdb_entry_t                   o_cdb_entry,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    cdb_entry_t     mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;

    logic           empty;
    logic           ready_c;
    logic           byp_req;
    logic           byp_hit;
    logic           pop;
    logic           push;

    // Handshake decode; ready never looks at the grant, so the grant has no path to ready.
    always_comb begin
        empty   = (count == '0);
        ready_c = (count != CW'(DEPTH)) & ~i_flush & i_reset_n;
`ifdef CDB_BYPASS_EN
        byp_req = empty & i_valid & ready_c;
`else
        byp_req = 1'b0;
`endif
        byp_hit = byp_req & i_bus_granted;
        pop     = ~empty & ~i_flush & i_bus_granted;
        push    = i_valid & ready_c & ~byp_hit;
    end

    // Bus-side outputs; the entry is zero unless this unit owns the bus.
    always_comb begin
        o_ready     = ready_c;
        o_get_bus   = (~empty & ~i_flush) | byp_req;
        o_cdb_valid = pop | byp_hit;
        o_cdb_entry = '0;
        if (pop) begin
            o_cdb_entry = mem[head];
        end else if (byp_hit) begin
            o_cdb_entry = i_entry;
        end
        o_count     = count;
    end

    // Pointer and occupancy update; flush squashes everything held.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage write; contents are don't-care after reset, so no reset here.
    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[tail] <= i_entry;
        end
    end

endmodule : cdb_result_buffer

// File: tb/tb_cdb_result_buffer.sv
// Self-checking bench for cdb_result_buffer: a cycle table plus reset corner cases,
// with popped bus entries checked against a queue of accepted results.
module tb_cdb_result_buffer;
    import cdb_result_buffer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       valid;
    cdb_entry_t entry;
    logic       ready;
    logic       get_bus;
    logic       granted;
    logic       cdb_valid;
    cdb_entry_t cdb_entry;
    logic [2:0] count;

    cdb_result_buffer #(.DEPTH(4)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_flush       (flush),
        .i_valid       (valid),
        .i_entry       (entry),
        .o_ready       (ready),
        .o_get_bus     (get_bus),
        .i_bus_granted (granted),
        .o_cdb_valid   (cdb_valid),
        .o_cdb_entry   (cdb_entry),
        .o_count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        g;
        logic        f;
        logic [31:0] d;
        logic        rdy;
        logic        gb;
        logic        cv;
        logic [2:0]  cnt;
    } vec_t;

    vec_t       vq[$];
    cdb_entry_t sb[$];
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic cdb_entry_t mk(input logic [31:0] d);
        cdb_entry_t e;
        e.data = d;
        e.rrn  = d[5:0] ^ 6'h2a;
        e.arn  = d[9:5];
        e.jmp  = d[0];
        e.err  = d[1];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic g, input logic f, input logic [31:0] d,
                       input logic rdy, input logic gb, input logic cv, input logic [2:0] cnt);
        vq.push_back('{v: v, g: g, f: f, d: d, rdy: rdy, gb: gb, cv: cv, cnt: cnt});
    endtask

    task automatic compare_pop(input string name);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'(cdb_valid), 64'(0));
        end else begin
            check({name, "_data"}, 64'(cdb_entry), 64'(sb.pop_front()));
        end
    endtask

    initial begin
        // Fill to full with no grant; fifth entry refused.
        add(1, 0, 0, 32'h11, 1, 0, 0, 0);
        add(1, 0, 0, 32'h22, 1, 1, 0, 1);
        add(1, 0, 0, 32'h33, 1, 1, 0, 2);
        add(1, 0, 0, 32'h44, 1, 1, 0, 3);
        add(1, 0, 0, 32'h55, 0, 1, 0, 4);
        // Drain in order, then a grant while not requesting.
        add(0, 1, 0, 32'h0,  0, 1, 1, 4);
        add(0, 1, 0, 32'h0,  1, 1, 1, 3);
        add(0, 1, 0, 32'h0,  1, 1, 1, 2);
        add(0, 1, 0, 32'h0,  1, 1, 1, 1);
        add(0, 1, 0, 32'h0,  1, 0, 0, 0);
        // Push and pop together at count 2.
        add(1, 0, 0, 32'h66, 1, 0, 0, 0);
        add(1, 0, 0, 32'h77, 1, 1, 0, 1);
        add(1, 1, 0, 32'h88, 1, 1, 1, 2);
        add(0, 0, 0, 32'h0,  1, 1, 0, 2);
        add(0, 1, 0, 32'h0,  1, 1, 1, 2);
        add(0, 1, 0, 32'h0,  1, 1, 1, 1);
        add(0, 0, 0, 32'h0,  1, 0, 0, 0);
        // Flush at count 3 beats valid and grant.
        add(1, 0, 0, 32'h91, 1, 0, 0, 0);
        add(1, 0, 0, 32'h92, 1, 1, 0, 1);
        add(1, 0, 0, 32'h93, 1, 1, 0, 2);
        add(1, 1, 1, 32'h94, 0, 0, 0, 3);
        add(0, 0, 0, 32'h0,  1, 0, 0, 0);
        // Empty buffer, valid with grant.
`ifdef CDB_BYPASS_EN
        add(1, 1, 0, 32'hAB, 1, 1, 1, 0);
        add(0, 1, 0, 32'h0,  1, 0, 0, 0);
`else
        add(1, 1, 0, 32'hAB, 1, 0, 0, 0);
        add(0, 1, 0, 32'h0,  1, 1, 1, 1);
`endif
        add(0, 0, 0, 32'h0,  1, 0, 0, 0);
        // Pop while full does not free a slot in the same cycle.
        add(1, 0, 0, 32'hC1, 1, 0, 0, 0);
        add(1, 0, 0, 32'hC2, 1, 1, 0, 1);
        add(1, 0, 0, 32'hC3, 1, 1, 0, 2);
        add(1, 0, 0, 32'hC4, 1, 1, 0, 3);
        add(1, 1, 0, 32'hC5, 0, 1, 1, 4);
        add(1, 0, 0, 32'hC6, 1, 1, 0, 3);
        add(0, 1, 0, 32'h0,  0, 1, 1, 4);
        add(0, 1, 0, 32'h0,  1, 1, 1, 3);
        add(0, 1, 0, 32'h0,  1, 1, 1, 2);
        add(0, 1, 0, 32'h0,  1, 1, 1, 1);
        add(0, 0, 0, 32'h0,  1, 0, 0, 0);

        rst_n   = 1'b0;
        flush   = 1'b0;
        valid   = 1'b1;
        granted = 1'b1;
        entry   = mk(32'hDEAD);

        // Outputs held quiet while reset is asserted.
        #2;
        check("rst_ready",   64'(ready),     64'(0));
        check("rst_get_bus", 64'(get_bus),   64'(0));
        check("rst_cdb_vld", 64'(cdb_valid), 64'(0));
        check("rst_entry",   64'(cdb_entry), 64'(0));
        check("rst_count",   64'(count),     64'(0));

        valid   = 1'b0;
        granted = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            valid   = vq[i].v;
            granted = vq[i].g;
            flush   = vq[i].f;
            entry   = mk(vq[i].d);
            @(negedge clk);
            check($sformatf("v%0d_ready", i),   64'(ready),     64'(vq[i].rdy));
            check($sformatf("v%0d_get_bus", i), 64'(get_bus),   64'(vq[i].gb));
            check($sformatf("v%0d_cdb_vld", i), 64'(cdb_valid), 64'(vq[i].cv));
            check($sformatf("v%0d_count", i),   64'(count),     64'(vq[i].cnt));
`ifdef CDB_BYPASS_EN
            if (vq[i].v && vq[i].rdy) sb.push_back(mk(vq[i].d));
            if (vq[i].cv) compare_pop($sformatf("v%0d", i));
            else check($sformatf("v%0d_idle_bus", i), 64'(cdb_entry), 64'(0));
`else
            if (vq[i].cv) compare_pop($sformatf("v%0d", i));
            else check($sformatf("v%0d_idle_bus", i), 64'(cdb_entry), 64'(0));
            if (vq[i].v && vq[i].rdy) sb.push_back(mk(vq[i].d));
`endif
            if (vq[i].f) sb.delete();
            @(posedge clk);
            #1;
        end

        // Reset pulled mid-cycle with two results held.
        valid   = 1'b1;
        granted = 1'b0;
        flush   = 1'b0;
        entry   = mk(32'hE1);
        @(posedge clk);
        #1;
        entry = mk(32'hE2);
        @(posedge clk);
        #1;
        valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count",   64'(count),   64'(0));
        check("mid_rst_get_bus", 64'(get_bus), 64'(0));
        check("mid_rst_ready",   64'(ready),   64'(0));
        granted = 1'b1;
        #1;
        check("mid_rst_cdb_vld", 64'(cdb_valid), 64'(0));
        check("mid_rst_entry",   64'(cdb_entry), 64'(0));
        sb.delete();
        granted = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready",   64'(ready),   64'(1));
        check("post_rst_get_bus", 64'(get_bus), 64'(0));

        // Buffer works normally again after reset.
        valid = 1'b1;
        entry = mk(32'hF00D);
        @(posedge clk);
        #1;
        valid   = 1'b0;
        granted = 1'b1;
        @(negedge clk);
        check("post_rst_cdb_vld", 64'(cdb_valid), 64'(1));
        check("post_rst_data",    64'(cdb_entry), 64'(mk(32'hF00D)));
        @(posedge clk);
        #1;
        granted = 1'b0;
        check("post_rst_drained", 64'(count), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_cdb_result_buffer
